branch_predictor_btb: RTL and testbench

- Fetch-side branch predictor, directly upstream of the E-stage branch resolution logic (BranchE / PCSrcE / FlushE path).
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Predicts next PC for PCF in F; trains from resolved branches in E; flags mispredictions and supplies the recovery PC to the hazard unit.

---
 rtl/branch_predictor_btb.sv | 91 +++++++++
 tb/tb_branch_predictor_btb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts in F from PCF, trains and detects mispredictions in E.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        TakenE,
  input  logic [31:0] TargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [INDEX_W-1:0] f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic [INDEX_W-1:0] e_idx;
  logic [TAG_W-1:0]   e_tag;
  logic               f_hit;
  logic               e_hit;
  logic               update_en;

  assign f_idx = PCF[INDEX_W+1:2];
  assign f_tag = PCF[31:INDEX_W+2];
  assign e_idx = PCE[INDEX_W+1:2];
  assign e_tag = PCE[31:INDEX_W+2];

  // Lookup reads the arrays directly, so a same-cycle update is seen next cycle.
  assign f_hit       = valid[f_idx] && (tag_mem[f_idx] == f_tag);
  assign PredTakenF  = f_hit && ctr_mem[f_idx][1];
  assign PredTargetF = PredTakenF ? target_mem[f_idx] : (PCF + 32'd4);

  assign update_en   = BranchE && !StallE;
  assign e_hit       = valid[e_idx] && (tag_mem[e_idx] == e_tag);
  assign MispredictE = update_en &&
                       ((PredTakenE != TakenE) ||
                        (PredTakenE && TakenE && (PredTargetE != TargetE)));
  assign RecoverPCE  = TakenE ? TargetE : (PCE + 32'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid        <= '0;
      BranchCount  <= '0;
      MispredCount <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i] <= 2'b01;
      end
    end else if (update_en) begin
      BranchCount <= BranchCount + 32'd1;
      if (MispredictE) begin
        MispredCount <= MispredCount + 32'd1;
      end
      if (e_hit) begin
        if (TakenE) begin
          if (ctr_mem[e_idx] != 2'b11) ctr_mem[e_idx] <= ctr_mem[e_idx] + 2'b01;
        end else begin
          if (ctr_mem[e_idx] != 2'b00) ctr_mem[e_idx] <= ctr_mem[e_idx] - 2'b01;
        end
      end else if (TakenE) begin
        valid[e_idx]   <= 1'b1;
        ctr_mem[e_idx] <= 2'b10;
      end
    end
  end

  // Tag/target carry no reset; valid guards them. Writing the tag on a taken
  // hit is harmless because it already matches.
  always_ff @(posedge clk) begin
    if (update_en && reset && TakenE) begin
      tag_mem[e_idx]    <= e_tag;
      target_mem[e_idx] <= TargetE;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed vector table, reset-in-flight
// sequence, then randomized traffic against an array-based reference model.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic        StallE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] TargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RecoverPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  branch_predictor_btb dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .BranchE(BranchE), .StallE(StallE), .PCE(PCE),
    .TakenE(TakenE), .TargetE(TargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE), .RecoverPCE(RecoverPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input logic [31:0] pcf, input logic br, input logic st,
                       input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    PCF = pcf; BranchE = br; StallE = st; PCE = pce;
    TakenE = tk; TargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
  endtask

  // reference model: whole-PC tags, integer counters clamped to 0..3
  bit          m_valid [16];
  logic [31:0] m_tagpc [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_bc, m_mc;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tagpc[i] == (pc / 64));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[m_index(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict(input bit br, input bit st, input bit tk,
                                      input logic [31:0] tgt, input bit ptk,
                                      input logic [31:0] ptgt);
    if (!br || st) return 1'b0;
    return (ptk != tk) || (ptk && tk && ptgt != tgt);
  endfunction

  function automatic void m_update(input bit br, input bit st, input logic [31:0] pc,
                                   input bit tk, input logic [31:0] tgt, input bit mis);
    int i = m_index(pc);
    if (!br || st) return;
    m_bc = m_bc + 1;
    if (mis) m_mc = m_mc + 1;
    if (m_hit(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1; m_tagpc[i] = pc / 64; m_tgt[i] = tgt; m_ctr[i] = 2;
    end
  endfunction

  typedef struct {
    logic [31:0] pcf; logic br; logic st; logic [31:0] pce; logic tk; logic [31:0] tgt;
    logic ptk; logic [31:0] ptgt;
    logic e_pt; logic [31:0] e_ptgt; logic e_mis; logic [31:0] e_rec, e_bc, e_mc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] pcf, input logic br, input logic st,
                              input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                              input logic ptk, input logic [31:0] ptgt, input logic e_pt,
                              input logic [31:0] e_ptgt, input logic e_mis,
                              input logic [31:0] e_rec, input logic [31:0] e_bc,
                              input logic [31:0] e_mc);
    vec_t v;
    v.pcf = pcf; v.br = br; v.st = st; v.pce = pce; v.tk = tk; v.tgt = tgt;
    v.ptk = ptk; v.ptgt = ptgt; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mis = e_mis;
    v.e_rec = e_rec; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [4];
    tags[0] = 32'd0; tags[1] = 32'd1; tags[2] = 32'd2; tags[3] = 32'h03FF_FFFF;
    return (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  vec_t vecs[14];

  initial begin
    logic [31:0] pcf, pce, tgt, ptgt;
    logic        br, st, tk, ptk, mis;

    // Expected values are observed before the edge that applies each row.
    vecs[0]  = mk(32'h10, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h14, 0, 32'h4,  0, 0);
    vecs[1]  = mk(32'h10, 1, 0, 32'h20, 1, 32'h40, 0, 32'h24, 0, 32'h14, 1, 32'h40, 0, 0);
    vecs[2]  = mk(32'h20, 1, 0, 32'h20, 0, 32'h0,  1, 32'h40, 1, 32'h40, 1, 32'h24, 1, 1);
    vecs[3]  = mk(32'h20, 1, 0, 32'h20, 0, 32'h0,  0, 32'h24, 0, 32'h24, 0, 32'h24, 2, 2);
    vecs[4]  = mk(32'h20, 1, 0, 32'h20, 0, 32'h0,  0, 32'h24, 0, 32'h24, 0, 32'h24, 3, 2);
    vecs[5]  = mk(32'h20, 1, 0, 32'h20, 1, 32'h40, 0, 32'h24, 0, 32'h24, 1, 32'h40, 4, 2);
    vecs[6]  = mk(32'h20, 1, 0, 32'h20, 1, 32'h40, 0, 32'h24, 0, 32'h24, 1, 32'h40, 5, 3);
    vecs[7]  = mk(32'h20, 1, 0, 32'h20, 1, 32'h44, 1, 32'h40, 1, 32'h40, 1, 32'h44, 6, 4);
    vecs[8]  = mk(32'h20, 1, 0, 32'h60, 1, 32'h80, 0, 32'h64, 1, 32'h44, 1, 32'h80, 7, 5);
    vecs[9]  = mk(32'h20, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h24, 0, 32'h4,  8, 6);
    vecs[10] = mk(32'h60, 1, 1, 32'h60, 0, 32'h0,  1, 32'h80, 1, 32'h80, 0, 32'h64, 8, 6);
    vecs[11] = mk(32'h60, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h80, 0, 32'h4,  8, 6);
    vecs[12] = mk(32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0,
                  0, 32'h0, 0, 32'h0, 8, 6);
    vecs[13] = mk(32'h63, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h80, 0, 32'h4,  8, 6);

    reset = 1'b0;
    drive(32'h10, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(vecs[k].pcf, vecs[k].br, vecs[k].st, vecs[k].pce, vecs[k].tk, vecs[k].tgt,
            vecs[k].ptk, vecs[k].ptgt);
      #1;
      check($sformatf("vec%0d PredTakenF", k),   32'(PredTakenF),  32'(vecs[k].e_pt));
      check($sformatf("vec%0d PredTargetF", k),  PredTargetF,      vecs[k].e_ptgt);
      check($sformatf("vec%0d MispredictE", k),  32'(MispredictE), 32'(vecs[k].e_mis));
      check($sformatf("vec%0d RecoverPCE", k),   RecoverPCE,       vecs[k].e_rec);
      check($sformatf("vec%0d BranchCount", k),  BranchCount,      vecs[k].e_bc);
      check($sformatf("vec%0d MispredCount", k), MispredCount,     vecs[k].e_mc);
    end

    // Reset dropped mid-stream with a taken branch presented: nothing may stick.
    @(negedge clk);
    drive(32'h60, 1, 0, 32'h20, 1, 32'h40, 0, 32'h24);
    reset = 1'b0;
    #1;
    check("rst PredTakenF 0x60", 32'(PredTakenF), 32'd0);
    check("rst PredTargetF 0x60", PredTargetF, 32'h64);
    check("rst BranchCount", BranchCount, 32'd0);
    check("rst MispredCount", MispredCount, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(32'h20, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #1;
    check("post-rst PredTakenF 0x20", 32'(PredTakenF), 32'd0);
    check("post-rst BranchCount", BranchCount, 32'd0);
    PCF = 32'h60;
    #1;
    check("post-rst PredTakenF 0x60", 32'(PredTakenF), 32'd0);

    // Randomized traffic; the model tracks the post-reset state.
    m_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      pce = rand_pc();
      pcf = ($urandom_range(0, 1) == 1) ? pce : rand_pc();
      br  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 4) == 0);
      tk  = ($urandom_range(0, 2) != 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 3) != 0) begin
        ptk = m_pred_taken(pce); ptgt = m_pred_target(pce);
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = $urandom;
      end
      drive(pcf, br, st, pce, tk, tgt, ptk, ptgt);
      #1;
      mis = m_mispredict(br, st, tk, tgt, ptk, ptgt);
      check("rnd PredTakenF", 32'(PredTakenF), 32'(m_pred_taken(pcf)));
      check("rnd PredTargetF", PredTargetF, m_pred_target(pcf));
      check("rnd MispredictE", 32'(MispredictE), 32'(mis));
      check("rnd RecoverPCE", RecoverPCE, tk ? tgt : pce + 32'd4);
      check("rnd BranchCount", BranchCount, m_bc);
      check("rnd MispredCount", MispredCount, m_mc);
      m_update(br, st, pce, tk, tgt, mis);
    end

    @(negedge clk);
    drive(32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #1;
    check("final BranchCount", BranchCount, m_bc);
    check("final MispredCount", MispredCount, m_mc);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
